// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and IF/ID payload for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned INSTR_WIDTH   = 32;
    localparam int unsigned ROM_BYTES     = 4096;

    localparam logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST     =
        RESET_VECTOR + ADDRESS_WIDTH'(ROM_BYTES) - ADDRESS_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0]   NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]   instr;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic                     valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

    // A fetch address is legal only if word-aligned and inside the ROM window.
    function automatic logic in_window(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= RESET_VECTOR) && (addr <= ROM_LAST);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats capture; resets to a bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_stall,
    input  logic [INSTR_WIDTH-1:0]   i_instr,
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    input  logic [ADDRESS_WIDTH-1:0] i_pc_plus4,
    input  logic                     i_valid,
    output logic [INSTR_WIDTH-1:0]   o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic [ADDRESS_WIDTH-1:0] o_pc_plus4,
    output logic                     o_valid
);

    if_id_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IF_ID_BUBBLE;
        end else if (!i_stall) begin
            r_q <= '{instr: i_instr, pc: i_pc, pc_plus4: i_pc_plus4, valid: i_valid};
        end
    end

    assign o_instr    = r_q.instr;
    assign o_pc       = r_q.pc;
    assign o_pc_plus4 = r_q.pc_plus4;
    assign o_valid    = r_q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM address and fills IF/ID.
// Any illegal PC update target halts fetch with a sticky fault until reset.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     redirect_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic [INSTR_WIDTH-1:0]   imem_data_i,
    output logic [INSTR_WIDTH-1:0]   instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o,
    output logic                     fault_o
);

    fetch_state_t             r_state;
    fetch_state_t             w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_nxt;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     r_fault;
    logic                     w_fault_nxt;
    logic                     w_ifid_flush;
    logic                     w_ifid_stall;
    logic                     w_ifid_valid;

    assign w_pc_plus4 = r_pc + ADDRESS_WIDTH'(4);
    assign w_target   = redirect_valid_i ? redirect_target_i : w_pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_fault_nxt  = r_fault;
        w_ifid_flush = 1'b0;
        w_ifid_stall = 1'b0;
        w_ifid_valid = 1'b1;
        unique case (r_state)
            BOOT: begin
                // Prime IF/ID from the reset vector without presenting it to decode.
                w_ifid_valid = 1'b0;
                w_state_nxt  = RUN;
            end
            RUN: begin
                w_ifid_flush = flush_i;
                w_ifid_stall = stall_i;
                if (redirect_valid_i || !stall_i) begin
                    if (in_window(w_target)) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = HALT;
                        // A sequential overrun still retires the last in-window word.
                        if (redirect_valid_i) begin
                            w_ifid_flush = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                w_ifid_flush = 1'b1;
            end
            default: begin
                w_state_nxt = HALT;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_ifid_flush),
        .i_stall    (w_ifid_stall),
        .i_instr    (imem_data_i),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .i_valid    (w_ifid_valid),
        .o_instr    (instr_o),
        .o_pc       (pc_o),
        .o_pc_plus4 (pc_plus4_o),
        .o_valid    (valid_o)
    );

    assign imem_addr_o = r_pc;
    assign fault_o     = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for sequential behaviour plus
// hand sequences for async reset, window-end overrun and out-of-window redirect.
module tb_fetch_unit;

    localparam logic [31:0] B   = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NV  = 17;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
    } vec_t;

    vec_t vecs[NV];

    fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall),
        .flush_i           (flush),
        .redirect_valid_i  (redir),
        .redirect_target_i (target),
        .imem_addr_o       (imem_addr),
        .imem_data_i       (imem_data),
        .instr_o           (instr),
        .pc_o              (pc),
        .pc_plus4_o        (pc4),
        .valid_o           (valid),
        .fault_o           (fault)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h0050_0093;
            32'hBFC0_0004: return 32'h0010_0113;
            32'hBFC0_0008: return 32'h0020_81B3;
            default:       return {a[15:0], 16'hA5C3};
        endcase
    endfunction

    assign imem_data = rom_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [31:0] t, input logic [31:0] a,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic v, input logic flt);
        vec_t x;
        x.stall = s; x.flush = f; x.redir = r; x.tgt = t;
        x.addr = a; x.instr = i; x.pc = p; x.valid = v; x.fault = flt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redir = r; target = t;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic [31:0] p4,
                             input logic v, input logic flt);
        chk({tag, " addr"},  imem_addr, a);
        chk({tag, " instr"}, instr, i);
        chk({tag, " pc"},    pc, p);
        chk({tag, " pc4"},   pc4, p4);
        chk({tag, " valid"}, 32'(valid), 32'(v));
        chk({tag, " fault"}, 32'(fault), 32'(flt));
    endtask

    task automatic chk_reset(input string tag);
        chk_state(tag, B, NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0,             B,        rom_word(B),        B,        0, 0);
        vecs[1]  = mk(0, 0, 0, 0,             B + 4,    rom_word(B),        B,        1, 0);
        vecs[2]  = mk(0, 0, 0, 0,             B + 8,    rom_word(B + 4),    B + 4,    1, 0);
        vecs[3]  = mk(1, 0, 0, 0,             B + 8,    rom_word(B + 4),    B + 4,    1, 0);
        vecs[4]  = mk(1, 0, 0, 0,             B + 8,    rom_word(B + 4),    B + 4,    1, 0);
        vecs[5]  = mk(1, 0, 0, 0,             B + 8,    rom_word(B + 4),    B + 4,    1, 0);
        vecs[6]  = mk(0, 0, 0, 0,             B + 12,   rom_word(B + 8),    B + 8,    1, 0);
        vecs[7]  = mk(0, 1, 1, B + 32'h40,    B + 32'h40, NOP,              0,        0, 0);
        vecs[8]  = mk(0, 0, 0, 0,             B + 32'h44, rom_word(B + 32'h40), B + 32'h40, 1, 0);
        vecs[9]  = mk(0, 0, 1, B + 32'h80,    B + 32'h80, rom_word(B + 32'h44), B + 32'h44, 1, 0);
        vecs[10] = mk(0, 0, 0, 0,             B + 32'h84, rom_word(B + 32'h80), B + 32'h80, 1, 0);
        vecs[11] = mk(0, 1, 0, 0,             B + 32'h88, NOP,              0,        0, 0);
        vecs[12] = mk(1, 0, 1, B + 32'h100,   B + 32'h100, NOP,             0,        0, 0);
        vecs[13] = mk(0, 0, 0, 0,             B + 32'h104, rom_word(B + 32'h100), B + 32'h100, 1, 0);
        vecs[14] = mk(0, 0, 1, B + 32'h42,    B + 32'h104, NOP,             0,        0, 1);
        vecs[15] = mk(0, 0, 0, 0,             B + 32'h104, NOP,             0,        0, 1);
        vecs[16] = mk(1, 1, 1, B + 32'h40,    B + 32'h104, NOP,             0,        0, 1);

        drive(0, 0, 0, 32'h0);
        rst = 1'b1;
        #2;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].stall, vecs[k].flush, vecs[k].redir, vecs[k].tgt);
            step();
            chk_state($sformatf("vec%0d", k), vecs[k].addr, vecs[k].instr, vecs[k].pc,
                      (vecs[k].pc == 32'h0) ? 32'h0 : vecs[k].pc + 32'd4,
                      vecs[k].valid, vecs[k].fault);
        end
        drive(0, 0, 0, 32'h0);

        // Asynchronous reset out of HALT, then normal fetch resumes.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset("halt_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("halt_rst boot valid", 32'(valid), 32'h0);
        step();
        chk_state("halt_rst run", B + 4, rom_word(B), B, B + 4, 1'b1, 1'b0);

        // Run to the last ROM word: it retires, then fetch faults without wrapping.
        drive(0, 0, 1, B + 32'hFF8);
        step();
        chk_state("end_a", B + 32'hFF8, rom_word(B + 4), B + 4, B + 8, 1'b1, 1'b0);
        drive(0, 0, 0, 32'h0);
        step();
        chk_state("end_b", B + 32'hFFC, rom_word(B + 32'hFF8), B + 32'hFF8, B + 32'hFFC, 1'b1, 1'b0);
        step();
        chk_state("end_c", B + 32'hFFC, rom_word(B + 32'hFFC), B + 32'hFFC, B + 32'h1000, 1'b1, 1'b1);
        step();
        chk_state("end_d", B + 32'hFFC, NOP, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        chk("end_e addr", imem_addr, B + 32'hFFC);

        // Asynchronous reset in the middle of a run.
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("mid pre addr", imem_addr, B + 4);
        #2 rst = 1'b1;
        #1 chk_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Redirect outside the window faults with the PC left at the reset vector.
        drive(0, 0, 1, 32'h8000_0000);
        step();
        chk_state("oow", B, NOP, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(0, 0, 0, 32'h0);
        step();
        chk_state("oow_hold", B, NOP, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue RISC-V core. Owns the program counter, drives the combinational instruction ROM address, and registers the returned 32-bit instruction word into the IF/ID pipeline register for decode. Handles stall, flush, control-flow redirect and out-of-window/misaligned fetch faults.

## Interface
- ADDRESS_WIDTH, 32, PC and ROM address width
- INSTR_WIDTH, 32, instruction word width (ROM assembles 4 bytes little-endian)
- RESET_VECTOR, 32'hBFC0_0000, PC value on reset; also ROM window base
- ROM_BYTES, 4096, ROM window size; valid fetch range RESET_VECTOR .. RESET_VECTOR+ROM_BYTES-4
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID register
- flush_i  in  1  squash IF/ID contents to a bubble
- redirect_valid_i  in  1  load PC from redirect_target_i (branch/jump taken)
- redirect_target_i  in  ADDRESS_WIDTH  new PC
- imem_addr_o  out  ADDRESS_WIDTH  byte address to ROM (= pc_q)
- imem_data_i  in  INSTR_WIDTH  ROM word, valid same cycle as imem_addr_o
- instr_o  out  INSTR_WIDTH  registered instruction for decode
- pc_o  out  ADDRESS_WIDTH  registered PC of instr_o
- pc_plus4_o  out  ADDRESS_WIDTH  pc_o + 4, registered
- valid_o  out  1  instr_o holds a real instruction
- fault_o  out  1  sticky fetch fault

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; one cycle; PC held at RESET_VECTOR, IF/ID loads ROM word → RUN.
- RUN next-PC priority: redirect_valid_i > stall_i > pc_q+4.
- Redirect while stalled still loads PC (redirect wins); IF/ID then follows flush/stall rules.
- IF/ID priority: flush_i > stall_i > capture {imem_data_i, pc_q, pc_q+4, valid=1}.
- Flush: instr_o ← 32'h0000_0013 (NOP), valid_o ← 0, pc_o/pc_plus4_o ← 0.
- Flush without redirect: PC still advances (or holds if stall_i).
- Redirect without flush: IF/ID captures the word currently at pc_q (no implicit squash).
- Fault check on every PC update target (redirect or pc_q+4): fault if addr[1:0]≠0 or addr outside ROM window. On fault: PC not updated, fault_o ← 1, IF/ID ← bubble, → HALT.
- PC wrap: pc_q = window end (RESET_VECTOR+ROM_BYTES-4) advancing → fault, no wrap to base.
- HALT: PC frozen, valid_o=0, fault_o=1; stall/flush/redirect ignored; exit only via rst.
- All arithmetic ADDRESS_WIDTH-bit unsigned; +4 carry out discarded (caught by window check).

## Timing
- Reset (async assert, immediate): pc_q=RESET_VECTOR, imem_addr_o=RESET_VECTOR, instr_o=NOP, pc_o=0, pc_plus4_o=0, valid_o=0, fault_o=0, state=BOOT.
- Deassert synchronous to clk by the reset source; first rising edge after deassert completes BOOT.
- Fetch latency: 1 cycle from pc_q to instr_o/valid_o.
- Redirect: redirect_valid_i at edge N → imem_addr_o=target after N → instr_o=target's word after N+1.
- stall_i/flush_i/redirect sampled at each rising edge; no combinational path from inputs to outputs except imem_data_i→(registered only).
- Reset mid-operation: all state returns to reset values asynchronously, including from HALT.

## Structure
- fetch_pkg: RESET_VECTOR, ROM_BYTES, ROM_LAST = RESET_VECTOR+ROM_BYTES-4, NOP_INSTR = 32'h0000_0013, fetch_state_t enum {BOOT, RUN, HALT}, if_id_t struct {instr, pc, pc_plus4, valid}.
- Sub-module if_id_reg: IF/ID register with stall/flush priority and async reset to bubble; fetch_unit holds PC, FSM, fault check.

## Test plan
- Reset then free-run, ROM words 0x00500093,0x00100113,0x002081B3 at 0xBFC00000.. → imem_addr_o 0xBFC00000,04,08; instr_o matches one cycle later; valid_o=1 from second edge after reset release.
- stall_i high 3 cycles at pc_q=0xBFC00008 → imem_addr_o, instr_o, pc_o constant 3 cycles, then resume with 0xBFC0000C.
- redirect_valid_i+flush_i, target 0xBFC00040 → next cycle valid_o=0, instr_o=0x00000013; following cycle pc_o=0xBFC00040, valid_o=1.
- Redirect target 0xBFC00042 (misaligned) or 0x80000000 → fault_o=1, valid_o=0, imem_addr_o unchanged, HALT persists until rst.
- Sequential run reaching pc_q=0xBFC00FFC → that word delivered with valid_o=1, next cycle fault_o=1, no wrap to 0xBFC00000.
- Assert rst asynchronously mid-run and from HALT → outputs at reset values before next clk edge; normal fetch from 0xBFC00000 after release.
